// File: rtl/pnode_pkg.sv
// pnode_pkg: shared types for the pnode tagging path.
//   pnode_t        packed egress beat {tag, sop, eop, payload}
//   pnode_state_e  tagger FSM state encoding
//   TAG_W, PNODE_W widths of the tag field and of a full egress beat
package pnode_pkg;

    localparam int TAG_W   = 8;
    localparam int DATA_W  = 128;
    localparam int PNODE_W = TAG_W + 2 + DATA_W;   // 138

    typedef struct packed {
        logic [TAG_W-1:0]  tag;       // [137:130]
        logic              sop;       // [129]
        logic              eop;       // [128]
        logic [DATA_W-1:0] payload;   // [127:0]
    } pnode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_DROP   = 2'd2
    } pnode_state_e;

endpackage

// File: rtl/pnode_skid2.sv
// pnode_skid2: 2-entry FIFO with valid/ready on both sides.
//   clock, resetn             clock, asynchronous active-low reset
//   s_data/s_valid/s_ready    write side; s_ready is registered "not full"
//   m_data/m_valid/m_ready    read side; m_data is the head entry
// A beat written into an empty FIFO is visible on m_* the next cycle, and a
// simultaneous push and pop keep the occupancy steady, so one beat per
// cycle flows with m_ready held high. Head data only moves on a pop, which
// keeps m_data stable while stalled.
module pnode_skid2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count   <= count_nxt;
            // Ready is looked ahead from the next occupancy so it is a flop.
            s_ready <= (count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/pnode_tagger_128.sv
// pnode_tagger_128: tags 128-bit packet beats with an 8-bit packet tag and
// forwards them through a 2-entry skid FIFO to the match block.
//   clock, resetn                     clock, asynchronous active-low reset
//   in_data/in_sop/in_eop             ingress beat and packet markers
//   in_valid/in_ready                 ingress handshake (in_ready = FIFO not full)
//   pnode_data/pnode_valid/pnode_ready egress {tag, sop, eop, payload}
//   drop_count                        saturating count of discarded beats
// Parameters: MAX_WORDS (max beats per packet), TAG_INIT (tag after reset).
// Build option: define PNODE_MAXLEN_EN to cut packets at MAX_WORDS beats
// (forced eop, then drop the remainder). Without it there is no length limit
// and no beat counter.
module pnode_tagger_128
    import pnode_pkg::*;
#(
    parameter int         MAX_WORDS = 95,
    parameter logic [7:0] TAG_INIT  = 8'd0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [127:0]       in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PNODE_W-1:0] pnode_data,
    output logic               pnode_valid,
    input  logic               pnode_ready,
    output logic [15:0]        drop_count
);

    pnode_state_e     state, state_nxt;
    logic [TAG_W-1:0] tag, tag_nxt;
    logic [15:0]      drop_nxt;
    logic             accept;
    logic             fwd;
    pnode_t           wbeat;
`ifdef PNODE_MAXLEN_EN
    logic [7:0]       beat_cnt, cnt_nxt;
    logic [7:0]       bnum;
    logic             forced;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt     = state;
        tag_nxt       = tag;
        drop_nxt      = drop_count;
        fwd           = 1'b0;
        wbeat.tag     = tag;
        wbeat.sop     = 1'b0;
        wbeat.eop     = 1'b0;
        wbeat.payload = in_data;
`ifdef PNODE_MAXLEN_EN
        cnt_nxt       = beat_cnt;
        bnum          = beat_cnt + 8'd1;
        forced        = 1'b0;
`endif
        if (accept) begin
            if (in_sop) begin
                // A sop inside a packet abandons the open one: the new packet
                // takes the next tag even though no eop closed the old one.
                fwd       = 1'b1;
                wbeat.sop = 1'b1;
                wbeat.tag = (state == ST_IN_PKT) ? tag + 8'd1 : tag;
`ifdef PNODE_MAXLEN_EN
                bnum      = 8'd1;
`endif
            end else if (state == ST_IN_PKT) begin
                fwd = 1'b1;
            end else begin
                // Beat outside a packet (IDLE, or the tail of a cut packet).
                if (drop_count != 16'hFFFF) drop_nxt = drop_count + 16'd1;
                if (state == ST_DROP && in_eop) state_nxt = ST_IDLE;
            end

            if (fwd) begin
                wbeat.eop = in_eop;
`ifdef PNODE_MAXLEN_EN
                forced    = (bnum == 8'(MAX_WORDS)) && !in_eop;
                wbeat.eop = in_eop | forced;
                cnt_nxt   = bnum;
`endif
                tag_nxt   = wbeat.eop ? wbeat.tag + 8'd1 : wbeat.tag;
                state_nxt = wbeat.eop ? ST_IDLE : ST_IN_PKT;
`ifdef PNODE_MAXLEN_EN
                if (forced) state_nxt = ST_DROP;
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            tag        <= TAG_INIT;
            drop_count <= 16'd0;
`ifdef PNODE_MAXLEN_EN
            beat_cnt   <= 8'd0;
`endif
        end else begin
            state      <= state_nxt;
            tag        <= tag_nxt;
            drop_count <= drop_nxt;
`ifdef PNODE_MAXLEN_EN
            beat_cnt   <= cnt_nxt;
`endif
        end
    end

    pnode_skid2 #(.W(PNODE_W)) u_skid (
        .clock   (clock),
        .resetn  (resetn),
        .s_data  (wbeat),
        .s_valid (fwd),
        .s_ready (in_ready),
        .m_data  (pnode_data),
        .m_valid (pnode_valid),
        .m_ready (pnode_ready)
    );

endmodule

// File: tb/tb_pnode_tagger_128.sv
// Directed bench for pnode_tagger_128: expected beats are queued by the
// stimulus with hand-derived tag/sop/eop and compared as they leave.
module tb_pnode_tagger_128;
    import pnode_pkg::*;

`ifdef PNODE_MAXLEN_EN
    localparam int MW = 8;
`else
    localparam int MW = 95;
`endif

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic [127:0]       in_data = '0;
    logic               in_sop = 1'b0;
    logic               in_eop = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PNODE_W-1:0] pnode_data;
    logic               pnode_valid;
    logic               pnode_ready = 1'b1;
    logic [15:0]        drop_count;

    always #5 clock = ~clock;

    pnode_tagger_128 #(.MAX_WORDS(MW), .TAG_INIT(8'd0)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pnode_data  (pnode_data),
        .pnode_valid (pnode_valid),
        .pnode_ready (pnode_ready),
        .drop_count  (drop_count)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    pnode_t exp_q[$];
    int     out_cyc[$];
    int     cyc = 0;
    int     n_out = 0;
    logic   stall_prev = 1'b0;
    logic [PNODE_W-1:0] data_prev = '0;
    logic   rnd_rdy = 1'b0;

    // Egress monitor: ordered compare plus hold-while-stalled check.
    always @(negedge clock) begin
        pnode_t e;
        cyc++;
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("stall_hold", pnode_data, data_prev);
            if (pnode_valid && pnode_ready) begin
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", pnode_data, e);
                end
                out_cyc.push_back(cyc);
                n_out++;
            end
            stall_prev = pnode_valid && !pnode_ready;
            data_prev  = pnode_data;
        end
    end

    always @(posedge clock) begin
        #1;
        if (rnd_rdy) pnode_ready = ($urandom_range(0, 3) == 0);
    end

    task automatic send(input logic [127:0] d, input logic s, input logic e, input logic fwd,
                        input logic [7:0] etag, input logic esop, input logic eeop);
        pnode_t b;
        int w = 0;
        in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (w >= 200) chk("in_ready_wait", in_ready, 1'b1);
        if (fwd) begin
            b.tag = etag; b.sop = esop; b.eop = eeop; b.payload = d;
            exp_q.push_back(b);
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 20000) begin
            @(posedge clock);
            w++;
        end
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_pnode_valid", pnode_valid, 1'b0);
        chk("rst_pnode_data", pnode_data, '0);
        chk("rst_drop_count", drop_count, 16'd0);
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;
        chk("in_ready_rise", in_ready, 1'b1);
    endtask

    initial begin
        int n0;
        int seq;
        int total;
        int len;

        // Three 6-beat packets, egress always ready: tags 0,1,2 back-to-back.
        do_reset();
        pnode_ready = 1'b1;
        n0 = n_out;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 6; b++)
                send(128'h1000 + 128'(p * 16 + b), b == 0, b == 5, 1'b1, 8'(p), b == 0, b == 5);
        idle();
        drain();
        chk("b2b_count", n_out - n0, 18);
        if (n_out - n0 == 18) chk("b2b_gapless", out_cyc[n0 + 17] - out_cyc[n0], 17);

        // Beats without sop after reset are dropped, nothing emitted.
        do_reset();
        n0 = n_out;
        send(128'hdead0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send(128'hdead1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        idle();
        repeat (3) @(posedge clock);
        #1;
        chk("drop_two", drop_count, 16'd2);
        chk("drop_no_output", n_out - n0, 0);
        send(128'h2000, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
        send(128'h2001, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1);
        // Single-beat packet stays in IDLE.
        send(128'h2100, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
        // sop on beat 3 restarts with tag 3; closing eop moves tag to 4.
        send(128'h2200, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
        send(128'h2201, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        send(128'h2202, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        send(128'h2203, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0);
        send(128'h2204, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1);
        send(128'h2300, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 1'b1);
        idle();
        drain();
        chk("midsop_drop_same", drop_count, 16'd2);

`ifdef PNODE_MAXLEN_EN
        // Packet of MW+3 beats: MW out with forced eop, 3 dropped, tag+1 next.
        do_reset();
        for (int b = 0; b < MW + 3; b++)
            send(128'h3000 + 128'(b), b == 0, b == MW + 2, b < MW, 8'd0, b == 0, b == MW - 1);
        send(128'h3100, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
        idle();
        drain();
        chk("maxlen_drop", drop_count, 16'd3);
`else
        // No length limit: a packet longer than MAX_WORDS passes intact.
        do_reset();
        for (int b = 0; b < MW + 5; b++)
            send(128'h3000 + 128'(b), b == 0, b == MW + 4, 1'b1, 8'd0, b == 0, b == MW + 4);
        send(128'h3100, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
        idle();
        drain();
        chk("nolimit_drop", drop_count, 16'd0);
`endif

        // 1000 packets against a 25%-duty egress: order, tag wrap, stall hold.
        do_reset();
        rnd_rdy = 1'b1;
        n0 = n_out;
        seq = 0;
        total = 0;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
                send(128'h5_0000 + 128'(seq), b == 0, b == len - 1, 1'b1, 8'(p), b == 0, b == len - 1);
                seq++;
                total++;
            end
        end
        idle();
        drain();
        rnd_rdy = 1'b0;
        @(posedge clock); #1;
        pnode_ready = 1'b1;
        chk("rand_count", n_out - n0, total);

        // Reset while the FIFO is full mid-packet.
        pnode_ready = 1'b0;
        send(128'h6000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        send(128'h6001, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        in_data = 128'h6002; in_valid = 1'b1;
        @(negedge clock);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_pnode_valid", pnode_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_async_valid", pnode_valid, 1'b0);
        chk("rst_async_ready", in_ready, 1'b0);
        idle();
        exp_q.delete();
        @(negedge clock) resetn = 1'b1;
        @(posedge clock); #1;
        pnode_ready = 1'b1;
        send(128'h7000, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
